// File: rtl/sprite_row_reader.sv
// Sprite row reader: tests each video line against the sprite, fetches the glyph
// row from the external ROM and serializes it as a per-pixel lit flag.
module sprite_row_reader #(
  parameter int unsigned SCALE_LOG2 = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start_i,
  input  logic        line_start_i,
  input  logic        pix_en_i,
  input  logic [9:0]  pixel_x_i,
  input  logic [9:0]  pixel_y_i,
  input  logic [9:0]  sprite_x_i,
  input  logic [9:0]  sprite_y_i,
  output logic [3:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        pixel_on_o,
  output logic        busy_o
);

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned ROW_W    = 16;
  localparam int unsigned COL_W    = 5;
  localparam int unsigned SUB_W    = 2;
  localparam int unsigned ROW_SPAN = 16 << SCALE_LOG2;
  localparam int unsigned SUB_LAST = (1 << SCALE_LOG2) - 1;
  localparam int unsigned COL_LAST = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    WAIT_X = 3'd3,
    DRAW   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   pos_x_q, pos_x_d;
  logic [COORD_W-1:0]   pos_y_q, pos_y_d;
  logic                 armed_q, armed_d;
  logic [3:0]           rom_addr_q, rom_addr_d;
  logic                 pixel_on_q, pixel_on_d;
  logic                 busy_q, busy_d;
  logic [ROW_W-1:0]     shreg_q, shreg_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [SUB_W-1:0]     sub_q, sub_d;

  // Row test sees a position loaded in this same cycle by frame_start.
  logic [COORD_W-1:0]   pos_y_eff_c;
  logic                 armed_eff_c;
  logic [COORD_W:0]     dy_c;
  logic                 line_hit_c;
  logic                 sub_last_c;
  logic                 strobe_c;

  assign pos_y_eff_c = frame_start_i ? sprite_y_i : pos_y_q;
  assign armed_eff_c = armed_q | frame_start_i;
  assign dy_c        = {1'b0, pixel_y_i} - {1'b0, pos_y_eff_c};
  assign line_hit_c  = armed_eff_c && !dy_c[COORD_W] &&
                       (dy_c[COORD_W-1:0] < COORD_W'(ROW_SPAN));
  assign sub_last_c  = (sub_q == SUB_W'(SUB_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      armed_q    <= 1'b0;
      rom_addr_q <= '0;
      pixel_on_q <= 1'b0;
      busy_q     <= 1'b0;
      shreg_q    <= '0;
      col_q      <= '0;
      sub_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      armed_q    <= armed_d;
      rom_addr_q <= rom_addr_d;
      pixel_on_q <= pixel_on_d;
      busy_q     <= busy_d;
      shreg_q    <= shreg_d;
      col_q      <= col_d;
      sub_q      <= sub_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    armed_d    = armed_q;
    rom_addr_d = rom_addr_q;
    pixel_on_d = pixel_on_q;
    shreg_d    = shreg_q;
    col_d      = col_q;
    sub_d      = sub_q;
    strobe_c   = 1'b0;

    if (frame_start_i) begin
      pos_x_d = sprite_x_i;
      pos_y_d = sprite_y_i;
      armed_d = 1'b1;
    end

    if (line_start_i) begin
      // A new line always restarts the row test, aborting any unfinished row.
      if (state_q != IDLE) begin
        pixel_on_d = 1'b0;
      end
      if (line_hit_c) begin
        rom_addr_d = 4'(dy_c[COORD_W-1:0] >> SCALE_LOG2);
        state_d    = FETCH;
      end else begin
        state_d    = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pix_en_i) pixel_on_d = 1'b0;
        end
        FETCH: begin
          if (pix_en_i) pixel_on_d = 1'b0;
          state_d = LATCH;
        end
        LATCH: begin
          if (pix_en_i) pixel_on_d = 1'b0;
          shreg_d = rom_data_i;
          col_d   = '0;
          sub_d   = '0;
          state_d = WAIT_X;
        end
        WAIT_X: begin
          if (pix_en_i) begin
            if (pixel_x_i == pos_x_q) begin
              strobe_c = 1'b1;
              state_d  = DRAW;
            end else begin
              pixel_on_d = 1'b0;
            end
          end
        end
        DRAW: begin
          if (pix_en_i) strobe_c = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // One displayed sub-pixel of the current glyph column.
    if (strobe_c) begin
      pixel_on_d = shreg_q[ROW_W-1];
      if (sub_last_c) begin
        sub_d   = '0;
        shreg_d = shreg_q << 1;
        col_d   = col_q + COL_W'(1);
        if (col_q == COL_W'(COL_LAST)) state_d = IDLE;
      end else begin
        sub_d   = sub_q + SUB_W'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign rom_addr_o = rom_addr_q;
  assign pixel_on_o = pixel_on_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_sprite_row_reader.sv
// Directed bench for sprite_row_reader: unscaled and 2x-scaled instances share
// timing stimulus and a small glyph ROM model.
module tb_sprite_row_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, line_start, pix_en;
  logic [9:0]  pixel_x, pixel_y, sprite_x, sprite_y;
  logic [3:0]  rom_addr0, rom_addr1;
  logic [15:0] rom_data0, rom_data1;
  logic        pixel_on0, pixel_on1, busy0, busy1;

  logic [15:0] rom [16];
  logic [255:0] lit0, lit1;
  logic        busy_seen;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign rom_data0 = rom[rom_addr0];
  assign rom_data1 = rom[rom_addr1];

  sprite_row_reader #(.SCALE_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .line_start_i(line_start),
    .pix_en_i(pix_en), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
    .sprite_x_i(sprite_x), .sprite_y_i(sprite_y), .rom_addr_o(rom_addr0),
    .rom_data_i(rom_data0), .pixel_on_o(pixel_on0), .busy_o(busy0)
  );

  sprite_row_reader #(.SCALE_LOG2(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .line_start_i(line_start),
    .pix_en_i(pix_en), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
    .sprite_x_i(sprite_x), .sprite_y_i(sprite_y), .rom_addr_o(rom_addr1),
    .rom_data_i(rom_data1), .pixel_on_o(pixel_on1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] span(input int lo, input int hi);
    logic [255:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    busy_seen = busy_seen | busy0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_frame(input logic [9:0] sx, input logic [9:0] sy);
    sprite_x = sx;
    sprite_y = sy;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_line(input logic [9:0] y, input logic fs);
    busy_seen   = 1'b0;
    lit0        = '0;
    lit1        = '0;
    pixel_y     = y;
    line_start  = 1'b1;
    frame_start = fs;
    tick();
    line_start  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic scan(input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      pix_en  = 1'b1;
      pixel_x = 10'(x);
      tick();
      lit0[x] = pixel_on0;
      lit1[x] = pixel_on1;
    end
    pix_en = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rom[r] = 16'h0000;
    rom[2]  = 16'h03C0;
    rom[15] = 16'hFFFF;
    rst_n = 1'b0; frame_start = 0; line_start = 0; pix_en = 0;
    pixel_x = '0; pixel_y = '0; sprite_x = 10'd100; sprite_y = 10'd50;
    busy_seen = 1'b0; lit0 = '0; lit1 = '0;
    #23;
    chk("reset_pixel_on", 256'(pixel_on0), 256'(0));
    chk("reset_rom_addr", 256'(rom_addr0), 256'(0));
    chk("reset_busy", 256'(busy0), 256'(0));
    tick();
    rst_n = 1'b1;
    idle(2);

    // Basic draw at (100,50)
    pulse_frame(10'd100, 10'd50);
    do_line(10'd52, 1'b0);
    chk("basic_rom_addr", 256'(rom_addr0), 256'(2));
    idle(4);
    scan(0, 255);
    chk("basic_pixels", lit0, span(106, 109));

    // Vertical misses keep the address and never go busy
    do_line(10'd49, 1'b0); idle(4); scan(0, 255);
    chk("miss49_rom_addr", 256'(rom_addr0), 256'(2));
    chk("miss49_busy", 256'(busy_seen), 256'(0));
    chk("miss49_pixels", lit0, '0);
    do_line(10'd66, 1'b0); idle(4); scan(0, 255);
    chk("miss66_rom_addr", 256'(rom_addr0), 256'(2));
    chk("miss66_busy", 256'(busy_seen), 256'(0));
    chk("miss66_pixels", lit0, '0);
    do_line(10'd65, 1'b0);
    chk("last_row_rom_addr", 256'(rom_addr0), 256'(15));
    idle(4); scan(0, 255);
    chk("last_row_pixels", lit0, span(100, 115));

    // Position latching
    sprite_x = 10'd200;
    do_line(10'd52, 1'b0); idle(4); scan(0, 255);
    chk("midframe_pixels", lit0, span(106, 109));
    pulse_frame(10'd200, 10'd50);
    do_line(10'd52, 1'b0); idle(4); scan(0, 255);
    chk("newframe_pixels", lit0, span(206, 209));
    sprite_x = 10'd100; sprite_y = 10'd40;
    do_line(10'd42, 1'b1);
    chk("same_cycle_rom_addr", 256'(rom_addr0), 256'(2));
    idle(4); scan(0, 255);
    chk("same_cycle_pixels", lit0, span(106, 109));

    // Abort in the middle of a row
    pulse_frame(10'd100, 10'd50);
    do_line(10'd65, 1'b0); idle(4); scan(0, 108);
    chk("abort_pre_pixel_on", 256'(pixel_on0), 256'(1));
    do_line(10'd52, 1'b0);
    chk("abort_pixel_on_cleared", 256'(pixel_on0), 256'(0));
    chk("abort_rom_addr", 256'(rom_addr0), 256'(2));
    pix_en = 1'b1; pixel_x = 10'd109;
    tick();
    pix_en = 1'b0;
    chk("abort_next_pix_en", 256'(pixel_on0), 256'(0));
    idle(3); scan(0, 255);
    chk("abort_refetch_pixels", lit0, span(106, 109));

    // Asynchronous reset in the middle of DRAW
    do_line(10'd65, 1'b0); idle(4); scan(0, 105);
    chk("predraw_pixel_on", 256'(pixel_on0), 256'(1));
    chk("predraw_busy", 256'(busy0), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("async_pixel_on", 256'(pixel_on0), 256'(0));
    chk("async_rom_addr", 256'(rom_addr0), 256'(0));
    chk("async_busy", 256'(busy0), 256'(0));
    tick();
    rst_n = 1'b1;
    idle(2);
    do_line(10'd0, 1'b0); idle(4); scan(0, 255);
    chk("unarmed_busy", 256'(busy_seen), 256'(0));
    chk("unarmed_pixels", lit0, '0);

    // 2x scaling on the second instance
    pulse_frame(10'd0, 10'd0);
    do_line(10'd5, 1'b0);
    chk("scale_rom_addr", 256'(rom_addr1), 256'(2));
    idle(4); scan(0, 255);
    chk("scale_pixels", lit1, span(12, 19));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_row_reader.md
# sprite_row_reader

Sprite row reader and pixel serializer: the consumer side of the 16x16 one-bit sprite glyph ROM (4-bit row address in, 16-bit row word out, combinational). For each video line it checks whether the line crosses the sprite and drives the ROM row address. It then latches the returned row word and shifts it out as a per-pixel `pixel_on` flag, synchronised to the display's pixel strobe. It sits between the video timing generator and the colour mux.

## Interface
- `SCALE_LOG2`, default 0: magnification exponent. Each glyph bit covers 2^SCALE_LOG2 by 2^SCALE_LOG2 screen pixels. Legal values are 0..2.
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `frame_start`  in  1  one-cycle pulse at the start of each frame.
- `line_start`  in  1  one-cycle pulse before the first pixel of a line. `pixel_y` is valid in this cycle.
- `pix_en`  in  1  pixel strobe; one pulse per displayed pixel.
- `pixel_x`  in  10  current column, valid when `pix_en`=1.
- `pixel_y`  in  10  current line, valid when `line_start`=1.
- `sprite_x`  in  10  sprite left edge, sampled on `frame_start`.
- `sprite_y`  in  10  sprite top edge, sampled on `frame_start`.
- `rom_addr`  out  4  row address to the glyph ROM (registered).
- `rom_data`  in  16  row word from the ROM. Bit 15 is the leftmost pixel.
- `pixel_on`  out  1  sprite pixel is lit (registered).
- `busy`  out  1  high while in FETCH, LATCH, WAIT_X or DRAW.

## Operation
- **Position registers.** `pos_x` and `pos_y` load from `sprite_x`/`sprite_y` on `frame_start`. Changes to the inputs mid-frame are ignored. The `armed` flag is cleared by reset and set on the first `frame_start`. While `armed`=0, no line is ever drawn.
- **Row test, on `line_start`.** Compute `dy = pixel_y - pos_y` at 11 bits, unsigned, with a borrow bit. The line hits the sprite iff there is no borrow and `dy < 16<<SCALE_LOG2`.
- **States.** IDLE, FETCH, LATCH, WAIT_X, DRAW.
- **IDLE.** On `line_start` with `armed` and a hit: set `rom_addr = dy >> SCALE_LOG2` and go to FETCH. On a miss, stay in IDLE and hold `rom_addr`.
- **FETCH.** One cycle so the ROM output settles. Go to LATCH.
- **LATCH.** Load `shreg <= rom_data`, clear `col` and `sub`, go to WAIT_X.
- **WAIT_X.** On `pix_en` with `pixel_x == pos_x`, go to DRAW and process that strobe as column 0.
- **DRAW.** On each `pix_en`:
  - `pixel_on <= shreg[15]`; increment `sub` (SCALE_LOG2 bits).
  - When `sub` wraps, shift `shreg` left by 1 and increment `col` (5 bits).
  - After the strobe for column 15's last sub-pixel, `pixel_on` returns to 0 on the next `pix_en`, and the state goes to IDLE.
- **`pixel_on` outside DRAW.** Updated to 0 on every `pix_en` when not in DRAW.
- **`line_start` in any non-IDLE state.** Abort, clear `pixel_on`, then re-run the row test exactly as from IDLE.
- **`frame_start` and `line_start` in the same cycle.** Position registers update first, and the row test uses the new position.
- **Right-edge overflow.** If `pos_x + (16<<SCALE_LOG2)` exceeds the line width, columns are cut off by the next `line_start`. No wrap to column 0 of the same line.
- **`pixel_x` never equals `pos_x` in a line.** Stay in WAIT_X until the next `line_start`.

## Timing
- **Reset values.** `rom_addr`=0, `pixel_on`=0, `busy`=0, state IDLE, `armed`=0, `pos_x`=`pos_y`=0, `shreg`=0.
- **Address to data.** `rom_addr` is valid one clock after `line_start`, and `rom_data` is captured 2 clocks after that. The minimum gap from `line_start` to the first `pix_en` is 4 clocks; `pix_en` sooner than that in the same line is treated as WAIT_X-ineligible.
- **Pixel latency.** `pixel_on` for the pixel presented with `pix_en` at clock N is valid from clock N+1 and holds until the next `pix_en`.
- **Continuous `pix_en`.** `pix_en` may be high every clock; no bubbles are required.
- **Asynchronous reset.** Reset mid-DRAW forces all reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-DRAW -> `pixel_on`=0, `rom_addr`=0 and `busy`=0 without a clock edge. After release and without `frame_start`, `line_start` at y=0 -> no `pixel_on`.
- **Basic draw, SCALE_LOG2=0.** Sprite at (100,50), `line_start` at y=52 -> `rom_addr`=2. With row 2 = 0x03C0, `pixel_on`=1 exactly for x=106..109, and 0 at x=105 and x=110..115.
- **Vertical misses.** Lines y=49 and y=66 with sprite_y=50 -> `busy` stays 0, `rom_addr` holds its previous value, and `pixel_on` is never 1. Line y=65 -> `rom_addr`=15.
- **Position latching.** Change `sprite_x` to 200 mid-frame -> the current frame still draws at x=100. After the next `frame_start` the sprite draws at 200. With `frame_start` and `line_start` in the same cycle, the new position is used for that line.
- **Abort.** `line_start` arrives while in DRAW at column 8 -> `pixel_on` is 0 on the next `pix_en`, and the new line re-fetches with the correct `rom_addr`.
- **Scaling, SCALE_LOG2=1.** Sprite at (0,0), line y=5 -> `rom_addr`=2, and `pixel_on`=1 for x=12..19 only.
